frame_to_uart_tx: RTL

FRAME_TO_UART_TX -- requirements
Module: frame_to_uart_tx

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/frame_to_uart_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and width helpers for the frame-to-UART serializer.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      GAP
   } tx_state_t;

   // Bits needed to hold any value from 0 up to and including n.
   function automatic int lenWidth(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_to_uart_tx.sv
// Serializes a latched multi-byte frame into single-byte SEND/BUSY handshakes
// towards a UART transmitter, with optional inter-byte gaps and an ack timeout.
module frame_to_uart_tx
   import uart_frame_pkg::*;
#(
   parameter int N_BYTES    = 51,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 0,
   parameter int ACK_TO     = 16,
   localparam int LW        = lenWidth(N_BYTES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*N_BYTES-1:0] data_in,
   input  logic [LW-1:0]        len,
   input  logic                 RCV,
   input  logic                 BUSY,
   output logic [7:0]           DATA_out,
   output logic                 SEND,
   output logic                 READY,
   output logic                 DONE,
   output logic                 ERR_OVR,
   output logic                 ERR_TO
);

   localparam int DW = 8 * N_BYTES;
   localparam int TW = lenWidth(maxOf(ACK_TO, GAP_CYCLES));
   localparam logic [LW-1:0] LEN_MAX = LW'(N_BYTES);

   tx_state_t       state_q, state_d;
   logic [DW-1:0]   mem_q, mem_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            send_q, send_d;
   logic            done_q, done_d;
   logic            errOvr_q, errOvr_d;
   logic            errTo_q, errTo_d;

   // State register: every piece of state, including the output pulses, is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_q    <= '0;
         cnt_q    <= '0;
         tmr_q    <= '0;
         send_q   <= 1'b0;
         done_q   <= 1'b0;
         errOvr_q <= 1'b0;
         errTo_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         send_q   <= send_d;
         done_q   <= done_d;
         errOvr_q <= errOvr_d;
         errTo_q  <= errTo_d;
      end
   end

   // Next-state logic; tmr_q doubles as the ack timeout and the inter-byte gap counter.
   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      send_d   = 1'b0;
      done_d   = 1'b0;
      errOvr_d = RCV && (state_q != IDLE);
      errTo_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (RCV) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  mem_d   = data_in;
                  cnt_d   = (len > LEN_MAX) ? LEN_MAX : len;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!BUSY) begin
               send_d  = 1'b1;
               tmr_d   = TW'(ACK_TO - 1);
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (BUSY) begin
               state_d = WAIT_LO;
            end else if (tmr_q == '0) begin
               errTo_d = 1'b1;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         WAIT_LO: begin
            if (!BUSY) begin
               mem_d = (MSB_FIRST != 0) ? (mem_q << 8) : (mem_q >> 8);
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LW'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (GAP_CYCLES > 0) begin
                  tmr_d   = TW'(GAP_CYCLES - 1);
                  state_d = GAP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         GAP: begin
            if (tmr_q == '0) begin
               state_d = ISSUE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The head byte only moves when WAIT_LO retires a byte, so DATA_out is stable across the handshake.
   assign DATA_out = (MSB_FIRST != 0) ? mem_q[DW-1 -: 8] : mem_q[7:0];
   assign SEND     = send_q;
   assign READY    = (state_q == IDLE);
   assign DONE     = done_q;
   assign ERR_OVR  = errOvr_q;
   assign ERR_TO   = errTo_q;

endmodule
